// File: rtl/cr_tlvp_chan_arb.sv
// cr_tlvp_chan_arb: round-robin TLV channel arbiter, frame-locked, with a 1-cycle output register.
// Ports: clk/rst_n (async active-low); in_valid/in_data/in_sot/in_eot/in_ready per channel;
// out_valid/out_data/out_sot/out_eot/out_chan/out_ready output beat; tlv_error pulse; frame_cnt.
// Optional stall watchdog enabled by macro CR_TLVP_ARB_WDOG_EN.
module cr_tlvp_chan_arb #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 64,
  parameter int WDOG_CYCLES = 256,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_sot,
  input  logic [N_CH-1:0]        in_eot,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sot,
  output logic                   out_eot,
  output logic [CH_W-1:0]        out_chan,
  input  logic                   out_ready,
  output logic                   tlv_error,
  output logic [31:0]            frame_cnt
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] g_q, g_d, rr_ptr_q, rr_ptr_d, gnt, ci;
  logic gnt_vld, slot_free, xfer, beat_sot, beat_eot, wdog_hit;
  logic [DATA_W-1:0] beat_data;
  logic out_valid_q, out_valid_d, out_sot_q, out_sot_d, out_eot_q, out_eot_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0] out_chan_q, out_chan_d;
  logic tlv_error_q, tlv_error_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  int idx;
  // Descending scan so the last hit wins, i.e. the first valid channel at or after rr_ptr.
  always_comb begin
    gnt = g_q;
    gnt_vld = 1'b0;
    idx = 0;
    ci = '0;
    if (state_q == LOCKED) gnt_vld = in_valid[g_q];
    else
      for (int i = N_CH - 1; i >= 0; i--) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
        ci = CH_W'(idx);
        if (in_valid[ci]) begin
          gnt = ci;
          gnt_vld = 1'b1;
        end
      end
  end
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (rst_n && slot_free && gnt_vld) ? N_CH'(1) << gnt : '0;
  assign xfer      = |in_ready;
  assign beat_data = in_data[int'(gnt)*DATA_W +: DATA_W];
  assign beat_sot  = in_sot[gnt];
  assign beat_eot  = in_eot[gnt];
`ifdef CR_TLVP_ARB_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  // Counts only genuine stalls of the locked channel; back-pressure with valid held does not count.
  always_comb begin
    wdog_d = wdog_q;
    wdog_hit = 1'b0;
    if (state_q != LOCKED || xfer) wdog_d = '0;
    else if (!in_valid[g_q]) begin
      wdog_hit = (wdog_q == 16'(WDOG_CYCLES - 1));
      wdog_d = wdog_hit ? '0 : wdog_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog_q <= '0;
    else wdog_q <= wdog_d;
`else
  assign wdog_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d = beat_eot ? IDLE : LOCKED;
      g_d = gnt;
      if (beat_eot) rr_ptr_d = (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + CH_W'(1);
    end
  end
  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = xfer ? beat_data : out_data_q;
    out_sot_d   = xfer ? beat_sot : out_sot_q;
    out_eot_d   = xfer ? beat_eot : out_eot_q;
    out_chan_d  = xfer ? gnt : out_chan_q;
    tlv_error_d = (xfer && ((state_q == IDLE) ? !beat_sot : beat_sot)) || wdog_hit;
    frame_cnt_d = frame_cnt_q + 32'(out_valid_q && out_ready && out_eot_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sot_q   <= 1'b0;
      out_eot_q   <= 1'b0;
      out_chan_q  <= '0;
      tlv_error_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sot_q   <= out_sot_d;
      out_eot_q   <= out_eot_d;
      out_chan_q  <= out_chan_d;
      tlv_error_q <= tlv_error_d;
      frame_cnt_q <= frame_cnt_d;
    end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sot   = out_sot_q;
  assign out_eot   = out_eot_q;
  assign out_chan  = out_chan_q;
  assign tlv_error = tlv_error_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/cr_tlvp_chan_arb.md
CR_TLVP_CHAN_ARB -- requirements
Module: cr_tlvp_chan_arb

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input TLV channels (legal 2..8).
REQ-002 SHALL have parameter DATA_W, default 64, data width per beat in bits.
REQ-003 SHALL have parameter WDOG_CYCLES, default 256, stall threshold in cycles for the watchdog (REQ-026).
REQ-004 SHALL use localparam CH_W = max(1, $clog2(N_CH)).
REQ-005 SHALL use one clock; reset is asynchronous and active-low:
  clk  input  1  sole clock, all state on rising edge
  rst_n  input  1  asynchronous active-low reset
REQ-006 SHALL have the following ports:
  in_valid  input  N_CH  per-channel beat valid
  in_data  input  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
  in_sot  input  N_CH  per-channel start-of-TLV flag
  in_eot  input  N_CH  per-channel end-of-TLV flag
  in_ready  output  N_CH  per-channel beat accept
  out_valid  output  1  output beat valid
  out_data  output  DATA_W  output beat data
  out_sot  output  1  output start-of-TLV
  out_eot  output  1  output end-of-TLV
  out_chan  output  CH_W  source channel of output beat
  out_ready  input  1  downstream accept
  tlv_error  output  1  one-cycle protocol-error pulse
  frame_cnt  output  32  completed frames, wraps

Function
REQ-007 SHALL transfer an input beat on channel c when in_valid[c] and in_ready[c] are both 1 in the same cycle.
REQ-008 SHALL assert in_ready[c] only for the granted channel c, and only when the output slot is free (!out_valid || out_ready).
REQ-009 SHALL implement FSM state IDLE (no frame in progress) and state LOCKED (frame in progress on channel g).
REQ-010 SHALL, in IDLE, grant the first channel with in_valid=1 in round-robin order starting at rr_ptr, combinationally in the same cycle.
REQ-011 SHALL, in IDLE, transition to LOCKED on a transferred beat with eot=0, latching g.
REQ-012 SHALL, in IDLE, remain in IDLE on a transferred beat with eot=1 (single-beat frame).
REQ-013 SHALL, in LOCKED, grant only channel g and ignore the other channels.
REQ-014 SHALL transition from LOCKED to IDLE on a transferred beat on g with eot=1.
REQ-015 SHALL set rr_ptr to (g+1) mod N_CH on every frame end, including single-beat frames; rr_ptr SHALL not change otherwise.
REQ-016 SHALL use a single output register stage with fixed latency of 1 cycle: a beat transferred in cycle t appears on out_* in cycle t+1.
REQ-017 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, when out_valid=1 and out_ready=1 and a new beat transfers in the same cycle, load the new beat with no bubble.
REQ-019 SHALL clear out_valid when out_ready=1 and no new beat is transferred.
REQ-020 SHALL pulse tlv_error for one cycle, on the cycle after a transferred beat, if that beat has sot=0 and was accepted in IDLE.
REQ-021 SHALL pulse tlv_error for one cycle, on the cycle after a transferred beat, if that beat has sot=1 and was accepted in LOCKED.
REQ-022 SHALL forward erroneous beats unchanged and SHALL apply the normal state transitions to them.
REQ-023 SHALL increment frame_cnt by 1 when out_valid, out_ready and out_eot are all 1, wrapping from 0xFFFFFFFF to 0.
REQ-024 SHALL not change state in any cycle with no valid input, except for output drain.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously set: state=IDLE, rr_ptr=0, g=0, out_valid=0, out_data=0, out_sot=0, out_eot=0, out_chan=0, tlv_error=0, frame_cnt=0, watchdog counter=0; in_ready SHALL be all 0. The first grant after reset SHALL go to the lowest-indexed valid channel. Reset mid-frame SHALL drop the partial frame without an error pulse.

Configuration
REQ-026 SHALL, when macro CR_TLVP_ARB_WDOG_EN is defined, implement a 16-bit counter that:
  - counts cycles in LOCKED with in_valid[g]=0;
  - resets on any transfer on g and on leaving LOCKED;
  - on reaching WDOG_CYCLES, pulses tlv_error for one cycle, restarts from 0, and keeps the lock.
REQ-027 SHALL, when CR_TLVP_ARB_WDOG_EN is undefined, omit the watchdog logic, so that tlv_error reflects REQ-020/021 only.

Verification
REQ-028 SHALL cover: ch0 and ch2 present 3-beat frames at once after reset, out_ready=1 -> ch0 beats in cycles 1-3, then ch2 beats in cycles 4-6, out_chan 0,0,0,2,2,2, frame_cnt=2.
REQ-029 SHALL cover: ch1 frame in LOCKED, ch3 valid throughout -> in_ready[3]=0 until ch1 eot, ch3 granted on the next cycle, rr_ptr=2 after ch1.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles mid-frame -> out_data stable, all in_ready=0, no beat lost or duplicated after release.
REQ-031 SHALL cover: ch0 sends sot=1, then sot=1 again without eot -> one tlv_error pulse one cycle after the 2nd beat, beat still forwarded; a separate sot=0 beat in IDLE -> one pulse.
REQ-032 SHALL cover: CR_TLVP_ARB_WDOG_EN defined, WDOG_CYCLES=8, ch2 stalls mid-frame 20 cycles -> tlv_error pulses at stall cycles 8 and 16, lock retained; macro undefined -> no pulse.
REQ-033 SHALL cover: rst_n asserted mid-frame on ch1 -> all outputs 0 at once; after release ch0 and ch1 both valid -> ch0 granted first.
